bit_packer: RTL and testbench

Streaming bit packer that accepts variable-length chunks (1..WIDTH valid LSBs) on a valid/ready input and emits dense WIDTH-bit words on a valid/ready output. Chunks are packed LSB-first, so earlier chunks land in lower bits. This matches the `{later, earlier}` ordering of the concat primitive the packer feeds. It sits directly upstream of the word-level concat/slice datapath and replaces fixed-width concat trees wherever field widths vary per beat.

---
 rtl/bit_packer_if.sv | 27 ++
 rtl/bit_packer.sv | 97 +++++++++
 tb/tb_bit_packer.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/bit_packer_if.sv
// bit_packer_if: stream bundle for the bit packer.
// The master side offers chunks and consumes words; the slave side is the packer.
interface bit_packer_if #(
  parameter int WIDTH = 16
);
  localparam int LEN_W = $clog2(WIDTH + 1);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [LEN_W-1:0] in_len;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [LEN_W-1:0] out_fill;

  modport master (
    output in_valid, in_data, in_len, flush, out_ready,
    input  in_ready, out_valid, out_data, out_fill
  );

  modport slave (
    input  in_valid, in_data, in_len, flush, out_ready,
    output in_ready, out_valid, out_data, out_fill
  );
endinterface

// File: rtl/bit_packer.sv
// bit_packer: packs variable-length chunks (LSB-first) into dense WIDTH-bit words.
// Optional feature macro: BIT_PACKER_FLUSH_EN enables flush and the DRAIN mode
// that emits a final partial word. Without it, flush is ignored and only full
// words are ever produced.
module bit_packer #(
  parameter int WIDTH = 16
) (
  input logic       clk,
  input logic       arst,
  bit_packer_if.slave bus
);
  localparam int LEN_W = $clog2(WIDTH + 1);
  localparam int ACC_W = 3 * WIDTH;
  localparam int CNT_W = $clog2(ACC_W);

  typedef logic [CNT_W-1:0] cnt_t;
  typedef logic [LEN_W-1:0] len_t;

  localparam cnt_t W_C  = cnt_t'(WIDTH);
  localparam cnt_t W2_C = cnt_t'(2 * WIDTH);
  localparam len_t W_L  = len_t'(WIDTH);

  logic [ACC_W-1:0] acc_reg, acc_next, acc_pop, chunk;
  cnt_t             cnt_reg, cnt_next, cnt_pop;
  len_t             fill, len_c;
  logic             drain, full, out_valid, pop, push;

  // Mask with the low n bits set.
  function automatic logic [WIDTH-1:0] low_mask(input len_t n);
    logic [WIDTH-1:0] m;
    for (int i = 0; i < WIDTH; i++) m[i] = (i < int'(n));
    return m;
  endfunction

  // Output decode from state only; no input-to-output path.
  always_comb begin
    full      = (cnt_reg >= W_C);
    out_valid = full || (drain && (cnt_reg != '0));
    fill      = '0;
    if (out_valid) fill = full ? W_L : cnt_reg[LEN_W-1:0];
  end

  assign bus.out_valid = out_valid;
  assign bus.out_fill  = fill;
  assign bus.out_data  = acc_reg[WIDTH-1:0] & low_mask(fill);
  assign bus.in_ready  = !drain && (cnt_reg < W2_C);

  // Next state: pop the emitted word first, then append the accepted chunk above what remains.
  always_comb begin
    pop      = out_valid && bus.out_ready;
    push     = bus.in_valid && bus.in_ready;
    len_c    = (bus.in_len > W_L) ? W_L : bus.in_len;
    chunk    = {{(ACC_W-WIDTH){1'b0}}, bus.in_data & low_mask(len_c)};
    acc_pop  = pop ? (acc_reg >> fill) : acc_reg;
    cnt_pop  = pop ? (cnt_reg - cnt_t'(fill)) : cnt_reg;
    acc_next = acc_pop;
    cnt_next = cnt_pop;
    if (push) begin
      acc_next = acc_pop | (chunk << cnt_pop);
      cnt_next = cnt_pop + cnt_t'(len_c);
    end
  end

  // Accumulator and bit count.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      acc_reg <= '0;
      cnt_reg <= '0;
    end else begin
      acc_reg <= acc_next;
      cnt_reg <= cnt_next;
    end
  end

`ifdef BIT_PACKER_FLUSH_EN
  typedef enum logic {FILL = 1'b0, DRAIN = 1'b1} mode_t;
  mode_t mode_reg;

  assign drain = (mode_reg == DRAIN);

  // FILL/DRAIN mode: enter on flush, leave once the buffer is empty.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      mode_reg <= FILL;
    end else if (mode_reg == FILL) begin
      if (bus.flush) mode_reg <= DRAIN;
    end else if (cnt_next == '0) begin
      mode_reg <= FILL;
    end
  end
`else
  logic unused_flush;

  assign drain        = 1'b0;
  assign unused_flush = bus.flush;
`endif
endmodule

// File: tb/tb_bit_packer.sv
// tb_bit_packer: directed checks of reset, packing order, masking, streaming,
// backpressure, length clamping and flush behaviour (both build options).
module tb_bit_packer;
  localparam int WIDTH = 16;

  logic clk;
  logic arst;
  int   n_checks = 0;
  int   n_fail   = 0;

  bit_packer_if #(.WIDTH(WIDTH)) bus ();

  bit_packer #(.WIDTH(WIDTH)) dut (
    .clk  (clk),
    .arst (arst),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_len   = '0;
    bus.flush    = 1'b0;
  endtask

  task automatic offer(input logic [15:0] data, input logic [4:0] len);
    bus.in_valid = 1'b1;
    bus.in_data  = data;
    bus.in_len   = len;
  endtask

  // Asynchronous reset pulse placed mid-cycle, with an immediate output check.
  task automatic mid_reset(input string tag);
    #2 arst = 1'b1;
    #1;
    check({tag, " out_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, " out_data"},  32'(bus.out_data),  32'h0000);
    check({tag, " out_fill"},  32'(bus.out_fill),  32'd0);
    check({tag, " in_ready"},  32'(bus.in_ready),  32'd1);
    #2 arst = 1'b0;
  endtask

  initial begin
    arst = 1'b1;
    idle();
    bus.out_ready = 1'b0;
    #12 arst = 1'b0;
    step();
    check("init out_valid", 32'(bus.out_valid), 32'd0);
    check("init in_ready",  32'(bus.in_ready),  32'd1);

    // Fill one word under backpressure, then reset asynchronously mid-cycle.
    offer(16'h5A5A, 5'd16);
    step();
    idle();
    check("prereset out_valid", 32'(bus.out_valid), 32'd1);
    mid_reset("rst1");
    $display("reset: async reset mid-word done");

    // Packing order: 0xA (4 bits) then 0x123 (12 bits).
    bus.out_ready = 1'b1;
    offer(16'hFFFA, 5'd4);
    step();
    check("pack partial out_valid", 32'(bus.out_valid), 32'd0);
    offer(16'hF123, 5'd12);
    step();
    idle();
    check("pack out_data", 32'(bus.out_data), 32'h123A);
    check("pack out_fill", 32'(bus.out_fill), 32'd16);
    step();
    check("pack after pop out_valid", 32'(bus.out_valid), 32'd0);
    $display("pack: 0xA + 0x123 -> 0x123A");

    // Masking: three len-8 chunks of 0xFFAB.
    offer(16'hFFAB, 5'd8);
    step();
    step();
    check("mask word out_data", 32'(bus.out_data), 32'hABAB);
    check("mask word out_fill", 32'(bus.out_fill), 32'd16);
    step();
    check("mask pending out_valid", 32'(bus.out_valid), 32'd0);
    $display("mask: 3 x 0xFFAB/8 -> 0xABAB, 8 bits pending");

    // Streaming: four full-width beats, one word per cycle.
    offer(16'hFFFF, 5'd16);
    for (int i = 0; i < 4; i++) begin
      step();
      check("stream out_valid", 32'(bus.out_valid), 32'd1);
      check("stream in_ready",  32'(bus.in_ready),  32'd1);
      check("stream out_data",  32'(bus.out_data),  (i == 0) ? 32'hFFAB : 32'hFFFF);
      $display("stream: beat %0d out_data=0x%04h", i, bus.out_data);
    end
    idle();
    step();
    check("stream drained out_valid", 32'(bus.out_valid), 32'd0);
    mid_reset("rst2");

    // Backpressure: third chunk refused, order preserved.
    step();
    bus.out_ready = 1'b0;
    offer(16'h1111, 5'd16);
    step();
    offer(16'h2222, 5'd16);
    step();
    check("bp in_ready at 32", 32'(bus.in_ready), 32'd0);
    offer(16'h3333, 5'd16);
    step();
    check("bp hold out_data", 32'(bus.out_data), 32'h1111);
    check("bp hold out_fill", 32'(bus.out_fill), 32'd16);
    check("bp still refused", 32'(bus.in_ready), 32'd0);
    bus.out_ready = 1'b1;
    step();
    check("bp second word", 32'(bus.out_data), 32'h2222);
    step();
    idle();
    check("bp third word", 32'(bus.out_data), 32'h3333);
    step();
    check("bp empty out_valid", 32'(bus.out_valid), 32'd0);
    $display("backpressure: order 0x1111 0x2222 0x3333");

    // Clamping and zero-length no-op.
    offer(16'hFFFF, 5'd0);
    step();
    check("len0 out_valid", 32'(bus.out_valid), 32'd0);
    offer(16'hBEEF, 5'd20);
    step();
    idle();
    check("clamp out_data", 32'(bus.out_data), 32'hBEEF);
    check("clamp out_fill", 32'(bus.out_fill), 32'd16);
    step();
    check("clamp popped", 32'(bus.out_valid), 32'd0);
    $display("clamp: len0 no-op, len20 -> 16 bits 0xBEEF");

    // Flush: 5 bits of 0x1F, then a flush pulse with the output stalled.
    bus.out_ready = 1'b0;
    offer(16'hFFFF, 5'd5);
    step();
    idle();
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
`ifdef BIT_PACKER_FLUSH_EN
    check("flush out_valid", 32'(bus.out_valid), 32'd1);
    check("flush out_data",  32'(bus.out_data),  32'h001F);
    check("flush out_fill",  32'(bus.out_fill),  32'd5);
    check("flush in_ready",  32'(bus.in_ready),  32'd0);
    step();
    check("flush hold in_ready", 32'(bus.in_ready), 32'd0);
    check("flush hold out_data", 32'(bus.out_data), 32'h001F);
    bus.out_ready = 1'b1;
    step();
    check("flush popped out_valid", 32'(bus.out_valid), 32'd0);
    check("flush popped in_ready",  32'(bus.in_ready),  32'd1);
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    check("flush empty out_valid", 32'(bus.out_valid), 32'd0);
    check("flush empty in_ready",  32'(bus.in_ready),  32'd0);
    step();
    check("flush empty back out_valid", 32'(bus.out_valid), 32'd0);
    check("flush empty back in_ready",  32'(bus.in_ready),  32'd1);
    $display("flush: partial 0x001F/5 emitted, empty flush silent");
`else
    check("noflush out_valid", 32'(bus.out_valid), 32'd0);
    check("noflush in_ready",  32'(bus.in_ready),  32'd1);
    offer(16'hF7FF, 5'd11);
    step();
    idle();
    check("noflush out_data", 32'(bus.out_data), 32'hFFFF);
    check("noflush out_fill", 32'(bus.out_fill), 32'd16);
    bus.out_ready = 1'b1;
    step();
    check("noflush popped", 32'(bus.out_valid), 32'd0);
    $display("flush disabled: 5 + 11 bits -> 0xFFFF");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
